// File: rtl/config_pkg.sv
// Shared configuration constants for the front-end predictor blocks.
package config_pkg;
    localparam int unsigned VLEN = 32;
endpackage

// File: rtl/bht_update_ctrl.sv
// BHT update controller: sweeps the table clear after reset/flush, then funnels
// two in-order resolved-branch update streams through a small FIFO onto one BHT write port.
module bht_update_ctrl #(
    parameter int unsigned VLEN       = config_pkg::VLEN,
    parameter int unsigned NR_ROWS    = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_bp_i,
    input  logic                       upd0_valid_i,
    input  logic [VLEN-1:0]            upd0_pc_i,
    input  logic                       upd0_taken_i,
    output logic                       upd0_ready_o,
    input  logic                       upd1_valid_i,
    input  logic [VLEN-1:0]            upd1_pc_i,
    input  logic                       upd1_taken_i,
    output logic                       upd1_ready_o,
    output logic                       bht_upd_valid_o,
    output logic [VLEN-1:0]            bht_upd_pc_o,
    output logic                       bht_upd_taken_o,
    output logic                       clr_valid_o,
    output logic [$clog2(NR_ROWS)-1:0] clr_index_o,
    output logic                       busy_o
);

    localparam int unsigned IW = $clog2(NR_ROWS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_sweep;
    logic [IW-1:0]   w_sweep_nxt;

    logic [VLEN-1:0]       r_pc_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_tk_mem;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    logic          w_run;
    logic          w_push0;
    logic          w_push1;
    logic          w_pop;
    logic [CW-1:0] w_free;
    logic [PW-1:0] w_wptr1;
    logic [CW-1:0] w_count_nxt;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_INIT;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
        end
    end

    // Next-state and clear-sweep outputs; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        clr_valid_o = 1'b0;
        clr_index_o = '0;
        busy_o      = 1'b0;
        case (r_state)
            S_INIT: begin
                clr_valid_o = 1'b1;
                clr_index_o = r_sweep;
                busy_o      = 1'b1;
                if (r_sweep == IW'(NR_ROWS - 1)) begin
                    w_state_nxt = S_RUN;
                    w_sweep_nxt = '0;
                end else begin
                    w_sweep_nxt = r_sweep + IW'(1);
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_INIT;
                w_sweep_nxt = '0;
            end
        endcase
        if (flush_bp_i) begin
            w_state_nxt = S_INIT;
            w_sweep_nxt = '0;
        end
    end

    // Acceptance uses only the registered occupancy, so a same-cycle pop gives no credit
    assign w_run        = (r_state == S_RUN);
    assign w_free       = CW'(FIFO_DEPTH) - r_count;
    assign upd0_ready_o = w_run && !flush_bp_i && (w_free >= CW'(1));
    assign upd1_ready_o = w_run && !flush_bp_i && (w_free >= CW'(2));
    assign w_push0      = upd0_valid_i && upd0_ready_o;
    assign w_push1      = upd1_valid_i && upd1_ready_o;
    assign w_pop        = w_run && (r_count != '0);
    assign w_wptr1      = r_wptr + PW'(w_push0);
    assign w_count_nxt  = r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);

    assign bht_upd_valid_o = w_pop;
    assign bht_upd_pc_o    = w_pop ? r_pc_mem[r_rptr] : '0;
    assign bht_upd_taken_o = w_pop ? r_tk_mem[r_rptr] : 1'b0;

    // Pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_bp_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_push0) + PW'(w_push1);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_count <= w_count_nxt;
        end
    end

    // Payload storage; pipe 0 lands ahead of pipe 1 so queue order is program order
    always_ff @(posedge clk_i) begin
        if (w_push0) begin
            r_pc_mem[r_wptr] <= upd0_pc_i;
            r_tk_mem[r_wptr] <= upd0_taken_i;
        end
        if (w_push1) begin
            r_pc_mem[w_wptr1] <= upd1_pc_i;
            r_tk_mem[w_wptr1] <= upd1_taken_i;
        end
    end

endmodule

// File: doc/bht_update_ctrl.md
BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

Interface
REQ-001 SHALL have parameter VLEN, default config_pkg::VLEN, the PC width.
REQ-002 SHALL have parameter NR_ROWS, default 1024, the BHT row count (power of two, >=2); IW = log2(NR_ROWS).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the update-queue entries (power of two, >=2).
REQ-004 SHALL have port clk_i  in  1  the single clock, rising edge.
REQ-005 SHALL have port rst_ni  in  1  the reset, asynchronous and active-low.
REQ-006 SHALL have port flush_bp_i  in  1  the predictor flush request.
REQ-007 SHALL have ports upd0_valid_i / upd1_valid_i  in  1  for resolved-branch updates from pipe 0 (older) and pipe 1 (younger).
REQ-008 SHALL have ports upd0_pc_i / upd1_pc_i  in  VLEN  for the branch PC.
REQ-009 SHALL have ports upd0_taken_i / upd1_taken_i  in  1  for the branch outcome.
REQ-010 SHALL have ports upd0_ready_o / upd1_ready_o  out  1  to accept the update.
REQ-011 SHALL have ports bht_upd_valid_o / bht_upd_pc_o / bht_upd_taken_o  out  1/VLEN/1  for the single BHT update port.
REQ-012 SHALL have ports clr_valid_o / clr_index_o  out  1/IW  for the BHT row-clear command.
REQ-013 SHALL have port busy_o  out  1  that is high while the clear sweep runs.

Function
REQ-014 SHALL implement the two-state FSM INIT and RUN.
REQ-015 In INIT: clr_valid_o=1; clr_index_o=sweep counter; counter increments by 1 per cycle; at counter NR_ROWS-1 the next state SHALL be RUN and the counter SHALL be 0.
REQ-016 A full sweep SHALL take exactly NR_ROWS cycles; busy_o SHALL equal (state==INIT).
REQ-017 In RUN, clr_valid_o SHALL be 0 and clr_index_o SHALL be 0.
REQ-018 flush_bp_i=1 in any state SHALL empty the FIFO and set state INIT with counter 0 next cycle; a flush during INIT SHALL restart the sweep from 0.
REQ-019 upd0_ready_o SHALL be RUN && !flush_bp_i && free>=1; upd1_ready_o SHALL be RUN && !flush_bp_i && free>=2; free = FIFO_DEPTH - registered count, with no same-cycle pop credit.
REQ-020 A push SHALL occur on valid&&ready per port; on a dual push, pipe 0 SHALL be written before pipe 1 (FIFO order = program order).
REQ-021 When only upd1 is pushed, it SHALL occupy a single slot.
REQ-022 bht_upd_valid_o SHALL be RUN && count!=0, with pc/taken taken from the FIFO head; when not valid, pc and taken SHALL be 0.
REQ-023 The BHT port SHALL be unconditionally consumed, so the head SHALL pop every cycle bht_upd_valid_o=1, giving at most 1 pop per cycle.
REQ-024 Latency SHALL be: an update accepted in cycle N appears on the BHT port no earlier than N+1 and in FIFO order.
REQ-025 Push and pop in the same cycle SHALL both take effect: count' = count + pushes - pop, with read/write pointers wrapping mod FIFO_DEPTH.
REQ-026 Count SHALL never exceed FIFO_DEPTH or underflow; no accepted update SHALL be lost except by flush.
REQ-027 Updates presented while ready is low SHALL NOT be latched; the requester SHALL hold them.

Reset
REQ-028 While rst_ni=0: state INIT, sweep counter 0, FIFO pointers and count 0; outputs SHALL be clr_valid_o=1, clr_index_o=0, busy_o=1, all ready=0, bht_upd_valid_o=0, bht_upd_pc_o=0, bht_upd_taken_o=0.
REQ-029 Reset asserted mid-sweep or mid-drain SHALL abandon all state immediately (asynchronously); after deassertion the sweep SHALL restart at row 0.

Verification (NR_ROWS=8, FIFO_DEPTH=4)
REQ-030 Release reset -> clr_index_o 0..7 on 8 consecutive cycles with busy_o=1, then RUN with readies high.
REQ-031 In RUN, dual push (pc 0x100 taken=1, 0x104 taken=0) in cycle N -> BHT port shows 0x100/1 at N+1 and 0x104/0 at N+2.
REQ-032 Hold both pipes valid with unique PCs for 10 cycles -> count never exceeds 4; upd1_ready_o=0 whenever free<2; output order equals acceptance order, with none lost.
REQ-033 Queue holds 3 entries, flush_bp_i pulses -> next cycle count=0, bht_upd_valid_o=0, and an 8-cycle sweep from 0; a flush at sweep index 5 restarts the sweep at 0.
REQ-034 Push while count=4 and a pop occurs the same cycle -> upd0_ready_o=0 (no pop credit); pointers wrap correctly across 3 full fill/drain rounds.
REQ-035 Assert rst_ni=0 mid-drain -> outputs take the REQ-028 values immediately, without waiting for a clock edge.
